// File: rtl/fixed_point_multiplier.sv
// Sequential signed Q8.8 multiplier: shift-add on operand magnitudes, one bit per
// clock, then symmetric round-half-up and saturation to Q8.8.
module fixed_point_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sign;
  logic [15:0] r_mag_a;
  logic [15:0] r_mag_b;
  logic [31:0] r_acc;
  logic [3:0]  r_count;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_product;
  logic        r_overflow;

  logic [31:0] w_addend;
  logic [31:0] w_rounded;
  logic [23:0] w_m;
  logic [15:0] w_product;
  logic        w_overflow;

  // 0x8000 maps to 32768, which still fits the unsigned 16-bit magnitude
  function automatic logic [15:0] abs16(input logic [15:0] v);
    abs16 = v[15] ? (16'd0 - v) : v;
  endfunction

  assign w_addend  = {16'd0, r_mag_a} << r_count;
  assign w_rounded = r_acc + 32'd128;
  assign w_m       = w_rounded[31:8];

  // Round/saturate the magnitude accumulator into a signed Q8.8 result
  always_comb begin
    w_product  = 16'h0000;
    w_overflow = 1'b0;
    if (!r_sign && (w_m > 24'd32767)) begin
      w_product  = 16'h7FFF;
      w_overflow = 1'b1;
    end else if (r_sign && (w_m > 24'd32768)) begin
      w_product  = 16'h8000;
      w_overflow = 1'b1;
    end else if (r_sign) begin
      w_product  = 16'd0 - w_m[15:0];
      w_overflow = 1'b0;
    end else begin
      w_product  = w_m[15:0];
      w_overflow = 1'b0;
    end
  end

  // Control FSM and datapath registers; all outputs are registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_mag_a     <= 16'd0;
      r_mag_b     <= 16'd0;
      r_acc       <= 32'd0;
      r_count     <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= 16'h0000;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= a[15] ^ b[15];
            r_mag_a    <= abs16(a);
            r_mag_b    <= abs16(b);
            r_acc      <= 32'd0;
            r_count    <= 4'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mag_b[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mag_b <= r_mag_b >> 1;
          r_count <= r_count + 4'd1;
          if (r_count == 4'd15) begin
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_product   <= w_product;
          r_overflow  <= w_overflow;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed, table-driven bench for the Q8.8 shift-add multiplier.
module tb_fixed_point_multiplier;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        overflow;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        ov;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  fixed_point_multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Waits for in_ready, presents operands for one edge, then scrambles them
  task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va;
    b = ~vb;
  endtask

  // Counts edges from acceptance until out_valid, bounded
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int idx, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ep, input logic eov);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    start_op(va, vb);
    wait_result(lat);
    check({tag, "_latency"}, lat, 32'd17);
    check({tag, "_product"}, {16'd0, product}, {16'd0, ep});
    check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, eov});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_rise"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_held"}, {16'd0, product}, {16'd0, ep});
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{16'h0180, 16'h0200, 16'h0300, 1'b0};
    vecs[1]  = '{16'hFE80, 16'h0200, 16'hFD00, 1'b0};
    vecs[2]  = '{16'hFE80, 16'hFE00, 16'h0300, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0080, 16'h0001, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'h0080, 16'hFFFF, 1'b0};
    vecs[5]  = '{16'h0001, 16'h0001, 16'h0000, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[8]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0};
    vecs[9]  = '{16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[10] = '{16'hFF00, 16'hFF00, 16'h0100, 1'b0};
    vecs[11] = '{16'h0080, 16'h0080, 16'h0040, 1'b0};
    vecs[12] = '{16'h0003, 16'h0080, 16'h0002, 1'b0};
    vecs[13] = '{16'hFFFD, 16'h0080, 16'hFFFE, 1'b0};
    vecs[14] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    vecs[15] = '{16'h4000, 16'h0200, 16'h7FFF, 1'b1};
    vecs[16] = '{16'hC000, 16'h0200, 16'h8000, 1'b0};

    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].ov);
    end

    // Backpressure: result held, new operands refused while DONE
    start_op(16'h0180, 16'h0200);
    wait_result(lat);
    check("bp_latency", lat, 32'd17);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        a = 16'h7FFF;
        b = 16'h7FFF;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_product_c%0d", k), {16'd0, product}, 32'h0300);
      check($sformatf("bp_in_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_out_valid_c%0d", k), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("bp_no_phantom_valid", {31'd0, out_valid}, 32'd0);
    check("bp_still_idle", {31'd0, in_ready}, 32'd1);
    check("bp_product_kept", {16'd0, product}, 32'h0300);

    // Reset in the middle of RUN aborts the operation
    start_op(16'h7FFF, 16'h7FFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_product", {16'd0, product}, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    run_vec(100, 16'h0100, 16'h0100, 16'h0100, 1'b0);

    // Reset while DONE discards the pending result
    start_op(16'h0180, 16'h0200);
    wait_result(lat);
    check("done_rst_latency", lat, 32'd17);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_product", {16'd0, product}, 32'd0);
    check("done_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
